// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Grants one byte, pulses tx_start, then waits for tx_done or watchdog expiry.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [DATA_W-1:0]          tx_data,
  output logic                       tx_start,
  input  logic                       tx_active,
  input  logic                       tx_done,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       timeout_err
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

  state_t            state;
  logic [ID_W-1:0]   ptr;
  logic [CNT_W-1:0]  wd_cnt;
  logic [DATA_W-1:0] req_byte [NUM_REQ];
  logic [ID_W-1:0]   winner;
  logic [ID_W-1:0]   cand_id;
  logic [ID_W-1:0]   next_ptr;
  logic              found;
  int unsigned       cand;

  // tx_active is status only and never steers the state machine.
  logic unused_tx_active;
  assign unused_tx_active = tx_active;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_byte[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    found   = 1'b0;
    winner  = '0;
    cand    = 0;
    cand_id = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 32'(ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_id = ID_W'(cand);
      if (!found && req_valid[cand_id]) begin
        found  = 1'b1;
        winner = cand_id;
      end
    end
    next_ptr = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
  end

  // Status outputs are registered from the current state, so they trail the
  // state register by one cycle (tx_start/busy rise one edge after the grant).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      tx_data     <= '0;
      grant_id    <= '0;
      req_ready   <= '0;
      tx_start    <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      wd_cnt      <= '0;
    end else begin
      tx_start    <= (state == START);
      busy        <= (state != IDLE);
      timeout_err <= 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        req_ready[i] <= (state == START) && (grant_id == ID_W'(i));
      end
      case (state)
        IDLE: begin
          if (found) begin
            tx_data  <= req_byte[winner];
            grant_id <= winner;
            ptr      <= next_ptr;
            state    <= START;
          end
        end
        START: begin
          wd_cnt <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          if (tx_done) begin
            state <= IDLE;
          end else if (TIMEOUT != 0) begin
            if (wd_cnt == CNT_W'(TIMEOUT - 1)) begin
              wd_cnt      <= CNT_W'(TIMEOUT);
              timeout_err <= 1'b1;
              state       <= IDLE;
            end else begin
              wd_cnt <= wd_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a round-robin reference model predicts
// grant order; a monitor checks grants, timing gaps, busy and the watchdog.
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int T = 64;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   tx_data;
  logic           tx_start;
  logic           tx_active = 1'b0;
  logic           tx_done = 1'b0;
  logic           busy;
  logic [1:0]     grant_id;
  logic           timeout_err;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(W), .TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_data(tx_data), .tx_start(tx_start),
    .tx_active(tx_active), .tx_done(tx_done), .busy(busy),
    .grant_id(grant_id), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         id;
    logic [7:0] data;
  } grant_t;

  int         checks = 0;
  int         failures = 0;
  grant_t     exp_q[$];
  logic [7:0] rq [N][$];
  int         m_ptr = 0;
  int         done_mode = 0;   // 0 random delay, 1 fixed delay, 2 never, 3 coincident with expiry
  int         done_delay = 5;
  int         inject_cyc = -1;
  int         done_cyc = -1;
  int         tmo_cyc = -1;
  int         last_end = -1;
  int         start_cyc = -1;
  int         exp_tmo = 0;
  int         got_tmo = 0;
  logic [7:0] last_byte = '0;
  bit         have_last = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit rq_empty();
    for (int i = 0; i < N; i++) if (rq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Reference: repeatedly grant the first non-empty requester at or after the pointer.
  task automatic schedule();
    int cnt[N];
    int pos[N];
    int total = 0;
    for (int i = 0; i < N; i++) begin
      cnt[i] = rq[i].size();
      pos[i] = 0;
      total += cnt[i];
    end
    while (total > 0) begin
      for (int k = 0; k < N; k++) begin
        int id = (m_ptr + k) % N;
        if (cnt[id] > 0) begin
          exp_q.push_back('{id, rq[id][pos[id]]});
          pos[id]++;
          cnt[id]--;
          total--;
          m_ptr = (id + 1) % N;
          break;
        end
      end
    end
    last_end = -1;
  endtask

  task automatic run_phase(input string name);
    int budget = 0;
    int quiet = 0;
    schedule();
    while (quiet < 6 && budget < 5000) begin
      @(negedge clk);
      budget++;
      if (exp_q.size() == 0 && !busy && rq_empty()) quiet++;
      else quiet = 0;
    end
    check({name, "_drain"}, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_grant_id"}, grant_id, 0);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_tx_start"}, tx_start, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  task automatic clear_model();
    exp_q.delete();
    for (int i = 0; i < N; i++) rq[i].delete();
    m_ptr = 0;
    done_cyc = -1;
    tmo_cyc = -1;
    last_end = -1;
    have_last = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    clear_model();
    repeat (2) @(negedge clk);
    check_reset_outputs(tag);
    reset = 1'b0;
  endtask

  // Requesters: present the head of each queue, advance on req_ready.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!reset && req_ready[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        req_valid[i] = (rq[i].size() > 0);
        req_data[i*W +: W] = (rq[i].size() > 0) ? rq[i][0] : 8'h00;
      end
    end
  end

  // Transmitter stand-in: completion pulse a chosen number of cycles after tx_start.
  initial begin
    int due = -1;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (reset) begin
        due = -1;
      end else begin
        if (tx_start && done_mode != 2) begin
          if (done_mode == 3)      due = cyc + T - 1;
          else if (done_mode == 1) due = cyc + done_delay;
          else                     due = cyc + int'($urandom_range(0, 30));
        end
        if (due >= 0 && cyc == due) begin
          tx_done = 1'b1;
          done_cyc = cyc;
          due = -1;
        end
        if (cyc == inject_cyc) tx_done = 1'b1;
      end
      tx_active = (due >= 0);
    end
  end

  // Monitor: pops the scoreboard on every tx_start.
  initial begin
    grant_t g;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (tx_start) begin
          if (exp_q.size() == 0) begin
            check("spurious_tx_start", tx_start, 0);
          end else begin
            g = exp_q.pop_front();
            check("grant_id", grant_id, g.id);
            check("tx_data", tx_data, g.data);
            check("req_ready_onehot", req_ready, 32'd1 << g.id);
            if (last_end >= 0) check("start_gap", cyc - last_end, 3);
            last_end  = -1;
            start_cyc = cyc;
            last_byte = g.data;
            have_last = 1'b1;
          end
        end else begin
          check("ready_without_start", req_ready, 0);
        end
        if (timeout_err) begin
          got_tmo++;
          check("timeout_cycle", cyc - start_cyc, T);
          tmo_cyc  = cyc;
          last_end = cyc - 1;
        end
        if (busy && have_last) check("tx_data_hold", tx_data, last_byte);
        if (done_cyc >= 0 && cyc == done_cyc + 1) begin
          check("busy_after_done", busy, 1);
          last_end = done_cyc;
        end
        if (done_cyc >= 0 && cyc == done_cyc + 2) check("busy_fall_done", busy, 0);
        if (tmo_cyc >= 0 && cyc == tmo_cyc + 1) check("busy_fall_timeout", busy, 0);
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b0;

    // Reset during an in-flight grant; a later tx_done must be ignored.
    done_mode = 2;
    rq[1].push_back(8'h77);
    schedule();
    n = 0;
    while (!tx_start && n < 50) begin @(negedge clk); n++; end
    check("mid_start_seen", tx_start, 1);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    clear_model();
    @(negedge clk);
    check_reset_outputs("mid");
    @(negedge clk);
    reset = 1'b0;
    inject_cyc = cyc + 2;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("post_reset_busy", busy, 0);
      check("post_reset_start", tx_start, 0);
    end
    inject_cyc = -1;

    done_mode = 1;
    done_delay = 20;
    rq[2].push_back(8'hA5);
    run_phase("single");

    do_reset("fair_rst");
    done_mode = 0;
    rq[0].push_back(8'h10); rq[0].push_back(8'h10);
    rq[1].push_back(8'h11); rq[1].push_back(8'h11);
    rq[2].push_back(8'h12);
    rq[3].push_back(8'h13);
    run_phase("fairness");

    rq[3].push_back(8'h33);
    run_phase("wrap_a");
    rq[0].push_back(8'h44);
    rq[3].push_back(8'h55);
    run_phase("wrap_b");

    done_mode = 2;
    rq[1].push_back(8'h61);
    rq[2].push_back(8'h62);
    exp_tmo += 2;
    run_phase("watchdog");
    check("timeout_count", got_tmo, exp_tmo);

    done_mode = 3;
    rq[0].push_back(8'h70);
    run_phase("coincident");
    check("coincident_no_err", got_tmo, exp_tmo);

    done_mode = 0;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) begin
        n = int'($urandom_range(0, 3));
        for (int j = 0; j < n; j++) rq[i].push_back(8'($urandom));
      end
      run_phase("random");
    end
    check("final_timeouts", got_tmo, exp_tmo);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
